// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side and memory-side signals around the memory arbiter.
// The slave view is the arbiter itself. The master view is the surrounding
// environment: both caches plus the memory model.
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128
);
  logic                 ic_req;
  logic [WORD_SIZE-1:0] ic_req_addr;
  logic                 ic_res;
  logic [WORD_SIZE-1:0] ic_res_addr;
  logic [LINE_SIZE-1:0] ic_res_data;

  logic                 dc_req;
  logic [WORD_SIZE-1:0] dc_req_addr;
  logic                 dc_res;
  logic [WORD_SIZE-1:0] dc_res_addr;
  logic [LINE_SIZE-1:0] dc_res_data;

  logic                 dc_wr;
  logic [WORD_SIZE-1:0] dc_wr_addr;
  logic [LINE_SIZE-1:0] dc_wr_data;
  logic                 dc_wr_busy;
  logic                 dc_wr_done;

  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_req_addr;
  logic                 mem_req_write;
  logic [LINE_SIZE-1:0] mem_req_data;
  logic                 mem_res;
  logic [WORD_SIZE-1:0] mem_res_addr;
  logic [LINE_SIZE-1:0] mem_res_data;

  modport slave (
    input  ic_req, ic_req_addr,
    output ic_res, ic_res_addr, ic_res_data,
    input  dc_req, dc_req_addr,
    output dc_res, dc_res_addr, dc_res_data,
    input  dc_wr, dc_wr_addr, dc_wr_data,
    output dc_wr_busy, dc_wr_done,
    output mem_req, mem_req_addr, mem_req_write, mem_req_data,
    input  mem_res, mem_res_addr, mem_res_data
  );

  modport master (
    output ic_req, ic_req_addr,
    input  ic_res, ic_res_addr, ic_res_data,
    output dc_req, dc_req_addr,
    input  dc_res, dc_res_addr, dc_res_data,
    output dc_wr, dc_wr_addr, dc_wr_data,
    input  dc_wr_busy, dc_wr_done,
    input  mem_req, mem_req_addr, mem_req_write, mem_req_data,
    output mem_res, mem_res_addr, mem_res_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between iCache refills, dCache refills
// and dCache write-backs. One pending slot per source, one transaction in
// flight, responses routed back by the state that issued the transaction.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no transaction outstanding; grant the best candidate
// BUSY_I   | iCache refill outstanding; mem_res goes to ic_res
// BUSY_DR  | dCache refill outstanding; mem_res goes to dc_res
// BUSY_DW  | dCache write-back outstanding; mem_res goes to dc_wr_done
module mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_DR, BUSY_DW} state_t;
  typedef enum logic [1:0] {G_NONE, G_I, G_DR, G_DW} grant_t;

  state_t               state;
  logic                 i_v;
  logic                 dr_v;
  logic                 dw_v;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] dr_addr;
  logic [WORD_SIZE-1:0] dw_addr;
  logic [LINE_SIZE-1:0] dw_data;
  logic                 favour_d;

  logic                 cap_i;
  logic                 cap_dr;
  logic                 cap_dw;
  grant_t               grant;
  logic [WORD_SIZE-1:0] i_addr_eff;
  logic [WORD_SIZE-1:0] dr_addr_eff;
  logic [WORD_SIZE-1:0] dw_addr_eff;
  logic [LINE_SIZE-1:0] dw_data_eff;
  logic                 dw_v_nxt;
  logic                 wr_flight_nxt;

  // Capture qualification, candidate selection and next write-slot occupancy.
  always_comb begin
    cap_i  = bus.ic_req && !i_v  && (state != BUSY_I);
    cap_dr = bus.dc_req && !dr_v && (state != BUSY_DR);
    cap_dw = bus.dc_wr  && !dw_v && (state != BUSY_DW);

    i_addr_eff  = i_v  ? i_addr  : bus.ic_req_addr;
    dr_addr_eff = dr_v ? dr_addr : bus.dc_req_addr;
    dw_addr_eff = dw_v ? dw_addr : bus.dc_wr_addr;
    dw_data_eff = dw_v ? dw_data : bus.dc_wr_data;

    // Write-back goes first so memory is updated before any refill of the line.
    grant = G_NONE;
    if (state == IDLE) begin
      if (dw_v || cap_dw) begin
        grant = G_DW;
      end else if ((i_v || cap_i) && (dr_v || cap_dr)) begin
        grant = favour_d ? G_DR : G_I;
      end else if (i_v || cap_i) begin
        grant = G_I;
      end else if (dr_v || cap_dr) begin
        grant = G_DR;
      end
    end

    dw_v_nxt      = (dw_v || cap_dw) && (grant != G_DW);
    wr_flight_nxt = (grant == G_DW) || ((state == BUSY_DW) && !bus.mem_res);
  end

  // Slot capture, grant issue, response routing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      i_v               <= 1'b0;
      dr_v              <= 1'b0;
      dw_v              <= 1'b0;
      i_addr            <= '0;
      dr_addr           <= '0;
      dw_addr           <= '0;
      dw_data           <= '0;
      favour_d          <= 1'b0;
      bus.ic_res        <= 1'b0;
      bus.ic_res_addr   <= '0;
      bus.ic_res_data   <= '0;
      bus.dc_res        <= 1'b0;
      bus.dc_res_addr   <= '0;
      bus.dc_res_data   <= '0;
      bus.dc_wr_busy    <= 1'b0;
      bus.dc_wr_done    <= 1'b0;
      bus.mem_req       <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_req_write <= 1'b0;
      bus.mem_req_data  <= '0;
    end else begin
      bus.mem_req    <= 1'b0;
      bus.ic_res     <= 1'b0;
      bus.dc_res     <= 1'b0;
      bus.dc_wr_done <= 1'b0;
      bus.dc_wr_busy <= dw_v_nxt || wr_flight_nxt;
      dw_v           <= dw_v_nxt;

      if (cap_i) begin
        i_v    <= 1'b1;
        i_addr <= bus.ic_req_addr;
      end
      if (cap_dr) begin
        dr_v    <= 1'b1;
        dr_addr <= bus.dc_req_addr;
      end
      if (cap_dw) begin
        dw_addr <= bus.dc_wr_addr;
        dw_data <= bus.dc_wr_data;
      end

      case (state)
        IDLE: begin
          case (grant)
            G_DW: begin
              bus.mem_req       <= 1'b1;
              bus.mem_req_addr  <= dw_addr_eff;
              bus.mem_req_write <= 1'b1;
              bus.mem_req_data  <= dw_data_eff;
              state             <= BUSY_DW;
            end
            G_I: begin
              bus.mem_req       <= 1'b1;
              bus.mem_req_addr  <= i_addr_eff;
              bus.mem_req_write <= 1'b0;
              bus.mem_req_data  <= '0;
              i_v               <= 1'b0;
              favour_d          <= 1'b1;
              state             <= BUSY_I;
            end
            G_DR: begin
              bus.mem_req       <= 1'b1;
              bus.mem_req_addr  <= dr_addr_eff;
              bus.mem_req_write <= 1'b0;
              bus.mem_req_data  <= '0;
              dr_v              <= 1'b0;
              favour_d          <= 1'b0;
              state             <= BUSY_DR;
            end
            default: ;
          endcase
        end
        BUSY_I: begin
          if (bus.mem_res) begin
            bus.ic_res      <= 1'b1;
            bus.ic_res_addr <= bus.mem_res_addr;
            bus.ic_res_data <= bus.mem_res_data;
            state           <= IDLE;
          end
        end
        BUSY_DR: begin
          if (bus.mem_res) begin
            bus.dc_res      <= 1'b1;
            bus.dc_res_addr <= bus.mem_res_addr;
            bus.dc_res_data <= bus.mem_res_data;
            state           <= IDLE;
          end
        end
        BUSY_DW: begin
          if (bus.mem_res) begin
            bus.dc_wr_done <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each task drives one scenario cycle by
// cycle and compares outputs #1 after the rising edge against hand-derived
// values. The bench plays both caches and the memory model.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_arbiter_if #(.WORD_SIZE(32), .LINE_SIZE(128)) bus ();

  mem_arbiter #(.WORD_SIZE(32), .LINE_SIZE(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ic_req       = 1'b0;
    bus.ic_req_addr  = '0;
    bus.dc_req       = 1'b0;
    bus.dc_req_addr  = '0;
    bus.dc_wr        = 1'b0;
    bus.dc_wr_addr   = '0;
    bus.dc_wr_data   = '0;
    bus.mem_res      = 1'b0;
    bus.mem_res_addr = '0;
    bus.mem_res_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.ic_req = 1'b1;
    bus.dc_wr  = 1'b1;
    bus.dc_wr_addr = 32'hFFFF_0000;
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req);
    end
    checks++;
    if (bus.mem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem_req_addr: got %h want 0", bus.mem_req_addr);
    end
    checks++;
    if (bus.dc_wr_busy !== 1'b0) begin
      errors++; $display("FAIL reset_dc_wr_busy: got %b want 0", bus.dc_wr_busy);
    end
    checks++;
    if ({bus.ic_res, bus.dc_res, bus.dc_wr_done, bus.mem_req_write} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 0000",
                         {bus.ic_res, bus.dc_res, bus.dc_wr_done, bus.mem_req_write});
    end
    checks++;
    if (bus.ic_res_data !== 128'h0 || bus.dc_res_addr !== 32'h0) begin
      errors++; $display("FAIL reset_res_regs: got ic_data=%h dc_addr=%h want 0",
                         bus.ic_res_data, bus.dc_res_addr);
    end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_icache_refill();
    logic saw_dc;
    logic extra_req;
    logic early_res;
    saw_dc = 1'b0;
    extra_req = 1'b0;
    early_res = 1'b0;
    do_reset();
    bus.ic_req      = 1'b1;
    bus.ic_req_addr = 32'h0000_1000;
    cyc();
    bus.ic_req = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_req_addr !== 32'h1000) begin
      errors++; $display("FAIL ic_issue: got req=%b addr=%h want 1/00001000",
                         bus.mem_req, bus.mem_req_addr);
    end
    checks++;
    if (bus.mem_req_write !== 1'b0 || bus.mem_req_data !== 128'h0) begin
      errors++; $display("FAIL ic_issue_rd: got write=%b data=%h want 0/0",
                         bus.mem_req_write, bus.mem_req_data);
    end
    for (int c = 2; c <= 8; c++) begin
      cyc();
      bus.mem_res      = (c == 6);
      bus.mem_res_addr = 32'h0000_1000;
      bus.mem_res_data = {16{8'hA5}};
      if (bus.dc_res) saw_dc = 1'b1;
      if (bus.mem_req) extra_req = 1'b1;
      if (c < 7 && bus.ic_res) early_res = 1'b1;
      if (c == 7) begin
        checks++;
        if (bus.ic_res !== 1'b1 || bus.ic_res_addr !== 32'h1000 ||
            bus.ic_res_data !== {16{8'hA5}}) begin
          errors++; $display("FAIL ic_response: got res=%b addr=%h data=%h want 1/00001000/a5..a5",
                             bus.ic_res, bus.ic_res_addr, bus.ic_res_data);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.ic_res !== 1'b0 || bus.ic_res_addr !== 32'h1000) begin
          errors++; $display("FAIL ic_response_hold: got res=%b addr=%h want 0/00001000",
                             bus.ic_res, bus.ic_res_addr);
        end
      end
    end
    checks++;
    if ({saw_dc, extra_req, early_res} !== 3'b000) begin
      errors++; $display("FAIL ic_quiet: got dc_res/extra_req/early_res=%b want 000",
                         {saw_dc, extra_req, early_res});
    end
  endtask

  task automatic test_writeback_first();
    do_reset();
    bus.dc_wr       = 1'b1;
    bus.dc_wr_addr  = 32'h0000_2000;
    bus.dc_wr_data  = {16{8'h11}};
    bus.dc_req      = 1'b1;
    bus.dc_req_addr = 32'h0000_2000;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      bus.dc_wr        = 1'b0;
      bus.dc_req       = 1'b0;
      bus.mem_res      = (c == 2 || c == 5);
      bus.mem_res_addr = 32'h0000_2000;
      bus.mem_res_data = (c == 5) ? {16{8'h22}} : 128'h0;
      if (c == 1) begin
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_req_write !== 1'b1 ||
            bus.mem_req_addr !== 32'h2000 || bus.mem_req_data !== {16{8'h11}}) begin
          errors++; $display("FAIL wb_issue: got req=%b wr=%b addr=%h data=%h want 1/1/00002000/11..11",
                             bus.mem_req, bus.mem_req_write, bus.mem_req_addr, bus.mem_req_data);
        end
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (bus.dc_wr_busy !== 1'b1) begin
          errors++; $display("FAIL wb_busy_c%0d: got %b want 1", c, bus.dc_wr_busy);
        end
      end
      if (c == 3) begin
        checks++;
        if (bus.dc_wr_done !== 1'b1 || bus.dc_wr_busy !== 1'b0 || bus.mem_req !== 1'b0) begin
          errors++; $display("FAIL wb_done: got done=%b busy=%b req=%b want 1/0/0",
                             bus.dc_wr_done, bus.dc_wr_busy, bus.mem_req);
        end
      end
      if (c == 4) begin
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_req_write !== 1'b0 ||
            bus.mem_req_addr !== 32'h2000 || bus.mem_req_data !== 128'h0) begin
          errors++; $display("FAIL wb_then_read: got req=%b wr=%b addr=%h data=%h want 1/0/00002000/0",
                             bus.mem_req, bus.mem_req_write, bus.mem_req_addr, bus.mem_req_data);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.dc_res !== 1'b1 || bus.dc_res_addr !== 32'h2000 ||
            bus.dc_res_data !== {16{8'h22}} || bus.dc_wr_done !== 1'b0) begin
          errors++; $display("FAIL wb_read_res: got res=%b addr=%h data=%h done=%b want 1/00002000/22..22/0",
                             bus.dc_res, bus.dc_res_addr, bus.dc_res_data, bus.dc_wr_done);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int          found;
    logic        pend;
    logic [31:0] last_addr;
    int          gc[4];
    logic [31:0] ga[4];
    logic [31:0] exp_addr;
    found = 0;
    pend = 1'b0;
    last_addr = '0;
    do_reset();
    bus.ic_req      = 1'b1;
    bus.ic_req_addr = 32'h0000_3000;
    bus.dc_req      = 1'b1;
    bus.dc_req_addr = 32'h0000_4000;
    for (int c = 1; c <= 30 && found < 4; c++) begin
      cyc();
      bus.mem_res      = pend;
      bus.mem_res_addr = last_addr;
      pend = 1'b0;
      if (bus.mem_req) begin
        gc[found] = c;
        ga[found] = bus.mem_req_addr;
        last_addr = bus.mem_req_addr;
        pend = 1'b1;
        found++;
      end
    end
    checks++;
    if (found != 4) begin
      errors++; $display("FAIL rr_timeout: got %0d grants want 4", found);
    end else begin
      checks++;
      if (gc[0] != 1) begin
        errors++; $display("FAIL rr_first_cycle: got %0d want 1", gc[0]);
      end
      for (int k = 0; k < 4; k++) begin
        exp_addr = (k % 2 == 0) ? 32'h3000 : 32'h4000;
        checks++;
        if (ga[k] !== exp_addr) begin
          errors++; $display("FAIL rr_grant%0d: got %h want %h", k, ga[k], exp_addr);
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (gc[k] - gc[k-1] != 3) begin
          errors++; $display("FAIL rr_spacing%0d: got %0d want 3", k, gc[k] - gc[k-1]);
        end
      end
    end
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    cyc();
    bus.mem_res = 1'b0;
  endtask

  task automatic test_capture_while_busy();
    logic extra_req;
    extra_req = 1'b0;
    do_reset();
    bus.ic_req      = 1'b1;
    bus.ic_req_addr = 32'h0000_5000;
    bus.dc_req_addr = 32'h0000_6000;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      bus.ic_req       = (c <= 3);
      bus.dc_req       = (c == 2);
      bus.mem_res      = (c == 5 || c == 8);
      bus.mem_res_addr = (c == 5) ? 32'h5000 : 32'h6000;
      bus.mem_res_data = (c == 5) ? {4{32'hCAFE_0001}} : {4{32'hD00D_0002}};
      if (c == 1) begin
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_req_addr !== 32'h5000) begin
          errors++; $display("FAIL cwb_ic_issue: got req=%b addr=%h want 1/00005000",
                             bus.mem_req, bus.mem_req_addr);
        end
      end
      if ((c >= 2 && c <= 6) || c >= 8) begin
        if (bus.mem_req) extra_req = 1'b1;
      end
      if (c == 6) begin
        checks++;
        if (bus.ic_res !== 1'b1 || bus.ic_res_addr !== 32'h5000 ||
            bus.ic_res_data !== {4{32'hCAFE_0001}}) begin
          errors++; $display("FAIL cwb_ic_res: got res=%b addr=%h data=%h want 1/00005000/cafe0001x4",
                             bus.ic_res, bus.ic_res_addr, bus.ic_res_data);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_req_addr !== 32'h6000 || bus.mem_req_write !== 1'b0) begin
          errors++; $display("FAIL cwb_dr_issue: got req=%b addr=%h wr=%b want 1/00006000/0",
                             bus.mem_req, bus.mem_req_addr, bus.mem_req_write);
        end
      end
      if (c == 9) begin
        checks++;
        if (bus.dc_res !== 1'b1 || bus.dc_res_addr !== 32'h6000 ||
            bus.dc_res_data !== {4{32'hD00D_0002}} || bus.ic_res !== 1'b0) begin
          errors++; $display("FAIL cwb_dr_res: got res=%b addr=%h data=%h ic_res=%b want 1/00006000/d00d0002x4/0",
                             bus.dc_res, bus.dc_res_addr, bus.dc_res_data, bus.ic_res);
        end
      end
    end
    checks++;
    if (extra_req !== 1'b0) begin
      errors++; $display("FAIL cwb_no_dup: got extra mem_req=%b want 0", extra_req);
    end
  endtask

  task automatic test_reset_mid_transaction();
    do_reset();
    bus.ic_req      = 1'b1;
    bus.ic_req_addr = 32'h0000_7000;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      rst              = (c == 3);
      bus.ic_req       = (c == 7);
      bus.ic_req_addr  = (c == 7) ? 32'h8000 : 32'h7000;
      bus.mem_res      = (c == 5 || c == 9);
      bus.mem_res_addr = (c == 5) ? 32'h7000 : 32'h8000;
      bus.mem_res_data = (c == 5) ? {16{8'h5A}} : {16{8'h3C}};
      if (c == 1) begin
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_req_addr !== 32'h7000) begin
          errors++; $display("FAIL rmt_issue: got req=%b addr=%h want 1/00007000",
                             bus.mem_req, bus.mem_req_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if ({bus.mem_req, bus.ic_res, bus.dc_res, bus.dc_wr_busy, bus.dc_wr_done} !== 5'b0 ||
            bus.mem_req_addr !== 32'h0) begin
          errors++; $display("FAIL rmt_after_reset: got flags=%b addr=%h want 00000/0",
                             {bus.mem_req, bus.ic_res, bus.dc_res, bus.dc_wr_busy, bus.dc_wr_done},
                             bus.mem_req_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.ic_res !== 1'b0 || bus.mem_req !== 1'b0 || bus.ic_res_data !== 128'h0) begin
          errors++; $display("FAIL rmt_stray: got ic_res=%b req=%b data=%h want 0/0/0",
                             bus.ic_res, bus.mem_req, bus.ic_res_data);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_req_addr !== 32'h8000) begin
          errors++; $display("FAIL rmt_fresh_issue: got req=%b addr=%h want 1/00008000",
                             bus.mem_req, bus.mem_req_addr);
        end
      end
      if (c == 10) begin
        checks++;
        if (bus.ic_res !== 1'b1 || bus.ic_res_addr !== 32'h8000 ||
            bus.ic_res_data !== {16{8'h3C}}) begin
          errors++; $display("FAIL rmt_fresh_res: got res=%b addr=%h data=%h want 1/00008000/3c..3c",
                             bus.ic_res, bus.ic_res_addr, bus.ic_res_data);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_icache_refill();
    test_writeback_first();
    test_round_robin();
    test_capture_while_busy();
    test_reset_mid_transaction();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
